// File: rtl/gate_share_ctrl_pkg.sv
// Shared definitions for the gate-sharing controller:
// state encoding, operand field offsets and the evaluator function.
package gate_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int OPND_A = 4;
    localparam int OPND_B = 3;
    localparam int OPND_C = 2;
    localparam int OPND_D = 1;
    localparam int OPND_E = 0;
    localparam int OPND_W = 5;

    localparam int CNT_W = 16;

    function automatic logic gate_eval(input logic [OPND_W-1:0] v);
        return ((v[OPND_A] & v[OPND_B]) ^ (v[OPND_C] | v[OPND_D]))
               | v[OPND_E];
    endfunction

endpackage

// File: rtl/gate_rr_arb.sv
// Combinational round-robin pick: first set request at or above
// the pointer, wrapping around; one-hot winner plus its index.
module gate_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    always_comb begin
        int k;
        k       = 0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!win_vld && req[k]) begin
                win_vld    = 1'b1;
                win_oh[k]  = 1'b1;
                win_idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/gate_share_ctrl.sv
// Round-robin controller sharing one 5-input gate evaluator
// among N_REQ requesters, with a valid/ready result port.
module gate_share_ctrl
    import gate_share_ctrl_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [OPND_W*N_REQ-1:0] i_opnd,
    output logic [N_REQ-1:0]        o_gnt,
    output logic                    o_busy,
    output logic                    o_y,
    output logic [IDX_W-1:0]        o_y_id,
    output logic                    o_y_vld,
    input  logic                    i_y_rdy,
    output logic [CNT_W-1:0]        o_done_cnt
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [OPND_W-1:0]  opnd_q, opnd_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               y_q, y_d;
    logic [IDX_W-1:0]   y_id_q, y_id_d;
    logic               vld_q, vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [OPND_W-1:0]  slot [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slot[g] = i_opnd[OPND_W*g +: OPND_W];
    end

    gate_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (i_req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opnd_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            y_q     <= 1'b0;
            y_id_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opnd_q  <= opnd_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            y_q     <= y_d;
            y_id_q  <= y_id_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        opnd_d  = opnd_q;
        gnt_d   = '0;
        y_d     = y_q;
        y_id_d  = y_id_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    id_d    = win_idx;
                    opnd_d  = slot[win_idx];
                    gnt_d   = win_oh;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                y_d     = gate_eval(opnd_q);
                y_id_d  = id_q;
                vld_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (i_y_rdy) begin
                    vld_d   = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    ptr_d   = (id_q == IDX_W'(N_REQ - 1))
                              ? '0 : id_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // busy mirrors the state being entered so it stays registered
        busy_d = (state_d != ST_IDLE);
    end

    assign o_gnt      = gnt_q;
    assign o_busy     = busy_q;
    assign o_y        = y_q;
    assign o_y_id     = y_id_q;
    assign o_y_vld    = vld_q;
    assign o_done_cnt = cnt_q;

endmodule

// File: tb/tb_gate_share_ctrl.sv
// Directed self-checking bench for gate_share_ctrl with
// hand-computed expectations and immediate assertions.
module tb_gate_share_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_req = '0;
    logic [19:0] i_opnd = '0;
    logic        i_y_rdy = 1'b0;
    logic [3:0]  o_gnt;
    logic        o_busy;
    logic        o_y;
    logic [1:0]  o_y_id;
    logic        o_y_vld;
    logic [15:0] o_done_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    gate_share_ctrl #(.N_REQ(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_opnd     (i_opnd),
        .o_gnt      (o_gnt),
        .o_busy     (o_busy),
        .o_y        (o_y),
        .o_y_id     (o_y_id),
        .o_y_vld    (o_y_vld),
        .i_y_rdy    (i_y_rdy),
        .o_done_cnt (o_done_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_gnt"}, 32'(o_gnt), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_y"}, 32'(o_y), 0);
        chk({tag, "_id"}, 32'(o_y_id), 0);
        chk({tag, "_vld"}, 32'(o_y_vld), 0);
        chk({tag, "_cnt"}, 32'(o_done_cnt), 0);
    endtask

    // one full transaction with ready held high
    task automatic txn(input logic [3:0] rv, input logic [19:0] op,
                       input int w, input logic ey, input bit hold);
        i_req = rv;
        i_opnd = op;
        i_y_rdy = 1'b1;
        tick();
        chk("gnt", 32'(o_gnt), 32'(1) << w);
        chk("busy", 32'(o_busy), 1);
        chk("vld_early", 32'(o_y_vld), 0);
        if (!hold) i_req[w] = 1'b0;
        tick();
        chk("vld", 32'(o_y_vld), 1);
        chk("y", 32'(o_y), 32'(ey));
        chk("y_id", 32'(o_y_id), 32'(w));
        chk("gnt_pulse", 32'(o_gnt), 0);
        tick();
        exp_cnt++;
        chk("xfer_vld", 32'(o_y_vld), 0);
        chk("cnt", 32'(o_done_cnt), 32'(exp_cnt));
    endtask

    logic [19:0] op_all;
    logic [3:0]  y_tab;

    initial begin
        #2;
        chk_idle_zero("reset");
        tick();
        tick();
        i_rst_n = 1'b1;
        chk_idle_zero("post_reset");

        // requester 0, a&b=1 -> y=1
        txn(4'b0001, 20'b00000_00000_00000_11000, 0, 1'b1, 1'b0);

        // requester 2 alone, three operand patterns
        txn(4'b0100, {5'b0, 5'b11100, 10'b0}, 2, 1'b0, 1'b0);
        txn(4'b0100, {5'b0, 5'b00001, 10'b0}, 2, 1'b1, 1'b0);
        txn(4'b0100, {5'b0, 5'b00000, 10'b0}, 2, 1'b0, 1'b0);

        // pointer now 3: 0101 wraps to 0, then 2
        txn(4'b0101, {5'b0, 5'b11100, 5'b0, 5'b00001}, 0, 1'b1, 1'b0);
        txn(4'b0100, {5'b0, 5'b11100, 5'b0, 5'b00001}, 2, 1'b0, 1'b0);
        txn(4'b1000, {5'b00001, 15'b0}, 3, 1'b1, 1'b0);

        // pointer back at 0: all held high gives 0,1,2,3,0,1,2,3
        op_all = {5'b11110, 5'b00001, 5'b11100, 5'b11000};
        y_tab  = 4'b0101;
        for (int i = 0; i < 8; i++)
            txn(4'b1111, op_all, i % 4, y_tab[i % 4], 1'b1);
        chk("cnt_after_rr", 32'(o_done_cnt), 15);

        // backpressure with requester 1
        i_y_rdy = 1'b0;
        i_req = 4'b0010;
        i_opnd = {10'b0, 5'b00110, 5'b0};
        tick();
        chk("bp_gnt", 32'(o_gnt), 32'b0010);
        i_req = 4'b0000;
        tick();
        chk("bp_vld", 32'(o_y_vld), 1);
        chk("bp_y", 32'(o_y), 1);
        chk("bp_id", 32'(o_y_id), 1);
        for (int i = 0; i < 5; i++) begin
            i_opnd = 20'($urandom);
            i_req = 4'b1111;
            tick();
            chk("bp_hold_vld", 32'(o_y_vld), 1);
            chk("bp_hold_y", 32'(o_y), 1);
            chk("bp_hold_id", 32'(o_y_id), 1);
            chk("bp_hold_busy", 32'(o_busy), 1);
            chk("bp_hold_cnt", 32'(o_done_cnt), 32'(exp_cnt));
        end
        i_req = 4'b0000;
        i_y_rdy = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_xfer_vld", 32'(o_y_vld), 0);
        chk("bp_xfer_busy", 32'(o_busy), 0);
        chk("bp_xfer_cnt", 32'(o_done_cnt), 32'(exp_cnt));
        tick();
        chk("bp_single_gnt", 32'(o_gnt), 0);
        chk("bp_single_vld", 32'(o_y_vld), 0);
        chk("bp_single_cnt", 32'(o_done_cnt), 32'(exp_cnt));

        // pointer 2: 0001 wraps to 0; reset hits during EVAL
        i_req = 4'b0001;
        i_opnd = 20'b00000_00000_00000_11000;
        tick();
        chk("pre_rst_gnt", 32'(o_gnt), 32'b0001);
        i_req = 4'b0000;
        i_rst_n = 1'b0;
        #1;
        chk_idle_zero("mid_rst");
        tick();
        chk("rst_hold_vld", 32'(o_y_vld), 0);
        i_rst_n = 1'b1;
        exp_cnt = 0;
        tick();
        chk("after_rst_vld", 32'(o_y_vld), 0);
        chk("after_rst_busy", 32'(o_busy), 0);
        // pointer must be 0 again, so 0110 grants 1 before 2
        txn(4'b0110, {10'b0, 5'b00110, 5'b0}, 1, 1'b1, 1'b0);
        txn(4'b0100, {5'b0, 5'b00001, 10'b0}, 2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_share_ctrl.md
Name: gate_share_ctrl

Overview:
- Round-robin scheduler that shares one 5-input gate evaluator among N_REQ requesters.
- Evaluator function: y = ((a & b) ^ (c | d)) | e.
- Each requester presents a 5-bit operand vector and a request. The controller grants one requester, captures its operands, evaluates them, and returns a tagged result under valid/ready backpressure.
- Sits between the requester-side logic and the shared gate datapath, and owns all sequencing of that datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 2, requester index width; equals clog2(N_REQ); derived, not overridden.

Ports:
- i_clk  input  1  single system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  request per requester; level, held until the matching o_gnt bit is seen.
- i_opnd  input  5*N_REQ  operands; slice k = bits [5k+4:5k] = {a,b,c,d,e}, a is MSB; held stable while i_req[k]=1.
- o_gnt  output  N_REQ  one-hot grant, one-cycle pulse.
- o_busy  output  1  high whenever the state is not IDLE.
- o_y  output  1  evaluated result.
- o_y_id  output  IDX_W  index of the requester that owns o_y.
- o_y_vld  output  1  result valid.
- i_y_rdy  input  1  consumer ready; a result transfers when o_y_vld & i_y_rdy.
- o_done_cnt  output  16  count of completed transfers; wraps at 0xFFFF to 0.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State IDLE, round-robin pointer 0.
  - o_gnt=0, o_busy=0, o_y=0, o_y_id=0, o_y_vld=0, o_done_cnt=0.
- States: IDLE, EVAL, RESP. All outputs are registered.
- IDLE:
  - At an edge with |i_req=1, pick winner w: first set bit of i_req, searching upward from the pointer with wrap-around.
  - Capture i_opnd slice w and w.
  - o_gnt[w]=1 for exactly the next cycle; move to EVAL.
  - If no request, stay in IDLE.
- EVAL:
  - At the next edge: o_y=f(captured), o_y_id=w, o_y_vld=1, o_gnt=0; move to RESP.
- RESP:
  - o_y, o_y_id and o_y_vld are held stable until i_y_rdy=1 at an edge.
  - On that edge: o_y_vld=0, o_done_cnt+1, pointer=(w+1) mod N_REQ; move to IDLE.
- Latency: request accepted at edge T, then o_gnt at T+1, then o_y_vld at T+2. Minimum 3 cycles per transaction with i_y_rdy held at 1.
- Requester rule:
  - Deassert i_req[k] after seeing o_gnt[k].
  - A request still high when the controller returns to IDLE counts as a new request.
- Fairness: the pointer moves only on a completed transfer. With all requests held high, grant order is 0,1,2,3,0,...
- i_req and i_opnd changes during EVAL/RESP are ignored; the captured operands are used.
- i_y_rdy outside RESP has no effect.
- Reset mid-operation: the transaction is discarded, no o_y_vld is produced, and the pointer returns to 0.
- o_done_cnt wraps silently.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, EVAL=2'd1, RESP=2'd2);
  - operand field offsets (A=4 .. E=0);
  - the counter width constant (16).
- Sub-module gate_rr_arb: combinational round-robin pick from i_req and the pointer, giving a one-hot winner plus its index.
- The gate function is evaluated inline in the EVAL update.

Test Plan:
- Reset, then req=4'b0001, opnd0=5'b11000, rdy=1 -> o_gnt=0001 at T+1; o_y=1, o_y_id=0, o_y_vld at T+2; done_cnt=1.
- Single requester 2 with opnd2=5'b11100, rdy=1 -> o_y=0, o_y_id=2. Then opnd2=5'b00001 -> o_y=1. Then opnd2=5'b00000 -> o_y=0.
- req=4'b1111 held, rdy=1 for 8 transactions -> grants in order 0,1,2,3,0,1,2,3; o_done_cnt=8.
- Backpressure: rdy=0 for 5 cycles in RESP while opnd changes -> o_y/o_y_id/o_y_vld stable. Asserting rdy gives one transfer only; o_busy drops the next cycle.
- Pointer at 3, req=4'b0101 -> grant requester 0 (wrap), then requester 2.
- Assert i_rst_n=0 during EVAL -> all outputs 0 immediately, no o_y_vld, pointer 0. Next req=4'b0110 -> grants requester 1 first.
